// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX pipeline register and the EX stage.
// The slave view belongs to id_ex_stage; the master view drives decode/forwarding.
interface id_ex_stage_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [31:0] id_pc;
    logic [3:0]  id_alu_control;
    logic        id_alu_src_a;
    logic        id_alu_src_b;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        flush;

    logic [4:0]  exm_rd;
    logic        exm_reg_write;
    logic [31:0] exm_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_result;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc;
    logic        stall_if_id;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
        input  id_alu_control, id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_read,
        input  id_mem_write, flush,
        input  exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
        output alu_a, alu_b, alu_control, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
        output ex_rd, ex_store_data, ex_pc, stall_if_id
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
        output id_alu_control, id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_read,
        output id_mem_write, flush,
        output exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
        input  alu_a, alu_b, alu_control, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
        input  ex_rd, ex_store_data, ex_pc, stall_if_id
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles and
// combinational EX/MEM and MEM/WB operand forwarding.
module id_ex_stage (
    input logic           clk,
    input logic           rst,
    id_ex_stage_if.slave  bus
);
    logic        ex_valid_q;
    logic        ex_reg_write_q;
    logic        ex_mem_read_q;
    logic        ex_mem_write_q;
    logic [3:0]  alu_control_q;
    logic [4:0]  ex_rd_q;
    logic [4:0]  ex_rs1_q;
    logic [4:0]  ex_rs2_q;
    logic [31:0] rs1_data_q;
    logic [31:0] rs2_data_q;
    logic [31:0] imm_q;
    logic [31:0] pc_q;
    logic        alu_src_a_q;
    logic        alu_src_b_q;

    logic        load_use;
    logic        bubble;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    always_comb begin
        load_use = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) & bus.id_valid &
                   ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
        // A flush kills the decode instruction, so there is nothing left to hold.
        bubble   = bus.flush | load_use | ~bus.id_valid;
    end

    assign bus.stall_if_id = load_use & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            alu_control_q  <= '0;
            ex_rd_q        <= '0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            pc_q           <= '0;
            alu_src_a_q    <= 1'b0;
            alu_src_b_q    <= 1'b0;
        end else if (bubble) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            alu_control_q  <= '0;
            ex_rd_q        <= '0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            pc_q           <= '0;
            alu_src_a_q    <= 1'b0;
            alu_src_b_q    <= 1'b0;
        end else begin
            ex_valid_q     <= 1'b1;
            ex_reg_write_q <= bus.id_reg_write;
            ex_mem_read_q  <= bus.id_mem_read;
            ex_mem_write_q <= bus.id_mem_write;
            alu_control_q  <= bus.id_alu_control;
            ex_rd_q        <= bus.id_rd;
            ex_rs1_q       <= bus.id_rs1;
            ex_rs2_q       <= bus.id_rs2;
            rs1_data_q     <= bus.id_rs1_data;
            rs2_data_q     <= bus.id_rs2_data;
            imm_q          <= bus.id_imm;
            pc_q           <= bus.id_pc;
            alu_src_a_q    <= bus.id_alu_src_a;
            alu_src_b_q    <= bus.id_alu_src_b;
        end
    end

    // The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
    function automatic logic [31:0] forward (
        input logic [4:0]  rs,
        input logic [31:0] latched,
        input logic [4:0]  exm_rd,
        input logic        exm_we,
        input logic [31:0] exm_res,
        input logic [4:0]  wb_rd,
        input logic        wb_we,
        input logic [31:0] wb_res
    );
        logic [31:0] r;
        r = latched;
        if (exm_we && exm_rd != '0 && exm_rd == rs)
            r = exm_res;
        else if (wb_we && wb_rd != '0 && wb_rd == rs)
            r = wb_res;
        return r;
    endfunction

    always_comb begin
        rs1_fwd = forward(ex_rs1_q, rs1_data_q, bus.exm_rd, bus.exm_reg_write, bus.exm_result,
                          bus.wb_rd, bus.wb_reg_write, bus.wb_result);
        rs2_fwd = forward(ex_rs2_q, rs2_data_q, bus.exm_rd, bus.exm_reg_write, bus.exm_result,
                          bus.wb_rd, bus.wb_reg_write, bus.wb_result);
    end

    assign bus.alu_a         = alu_src_a_q ? pc_q  : rs1_fwd;
    assign bus.alu_b         = alu_src_b_q ? imm_q : rs2_fwd;
    assign bus.ex_store_data = rs2_fwd;
    assign bus.alu_control   = alu_control_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.ex_mem_write  = ex_mem_write_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ex_pc         = pc_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each cycle's EX outputs,
// a negedge monitor compares them; directed sequences add fixed-value checks.
module tb_id_ex_stage;
    logic clk;
    logic rst;
    id_ex_stage_if bus ();

    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc;
        logic [3:0]  ctl;
        logic        sa, sb, rw, mr, mw;
    } instr_t;

    typedef struct packed {
        instr_t      id;
        logic        flush;
        logic [4:0]  exm_rd;
        logic        exm_we;
        logic [31:0] exm_res;
        logic [4:0]  wb_rd;
        logic        wb_we;
        logic [31:0] wb_res;
    } stim_t;

    typedef struct packed {
        logic        stall, valid, rw, mr, mw;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic [31:0] a, b, sd, pc;
    } exp_t;

    exp_t   exp_q[$];
    instr_t in_ex;
    instr_t next_in_ex;
    logic   last_stall;
    int     total = 0;
    int     bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Value an instruction in EX reads for a source register, given the writebacks in flight.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] regval, input stim_t s);
        if (r == 0) return regval;
        if (s.exm_we && s.exm_rd == r) return s.exm_res;
        if (s.wb_we && s.wb_rd == r) return s.wb_res;
        return regval;
    endfunction

    function automatic logic hazard(input instr_t ex, input stim_t s);
        return ex.valid && ex.mr && ex.rd != 0 && s.id.valid && (ex.rd == s.id.rs1 || ex.rd == s.id.rs2);
    endfunction

    function automatic exp_t predict(input instr_t ex, input stim_t s);
        exp_t e;
        logic [31:0] v1, v2;
        v1 = operand(ex.rs1, ex.d1, s);
        v2 = operand(ex.rs2, ex.d2, s);
        e.stall = hazard(ex, s) && !s.flush;
        e.valid = ex.valid;
        e.rw    = ex.valid & ex.rw;
        e.mr    = ex.valid & ex.mr;
        e.mw    = ex.valid & ex.mw;
        e.ctl   = ex.valid ? ex.ctl : 4'd0;
        e.rd    = ex.valid ? ex.rd : 5'd0;
        e.a     = ex.sa ? ex.pc : v1;
        e.b     = ex.sb ? ex.imm : v2;
        e.sd    = v2;
        e.pc    = ex.pc;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.id.valid = ($urandom_range(0, 99) < 85);
        s.id.rs1   = 5'($urandom_range(0, 7));
        s.id.rs2   = 5'($urandom_range(0, 7));
        s.id.rd    = 5'($urandom_range(0, 7));
        s.id.d1    = $urandom;
        s.id.d2    = $urandom;
        s.id.imm   = $urandom;
        s.id.pc    = $urandom;
        s.id.ctl   = 4'($urandom_range(0, 9));
        s.id.sa    = 1'($urandom_range(0, 1));
        s.id.sb    = 1'($urandom_range(0, 1));
        s.id.mr    = ($urandom_range(0, 2) == 0);
        s.id.mw    = !s.id.mr && ($urandom_range(0, 4) == 0);
        s.id.rw    = s.id.mr || ($urandom_range(0, 1) == 1);
        s.flush    = ($urandom_range(0, 99) < 8);
        s.exm_rd   = 5'($urandom_range(0, 7));
        s.exm_we   = 1'($urandom_range(0, 1));
        s.exm_res  = $urandom;
        s.wb_rd    = 5'($urandom_range(0, 7));
        s.wb_we    = 1'($urandom_range(0, 1));
        s.wb_res   = $urandom;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.id_valid       = s.id.valid;
        bus.id_rs1         = s.id.rs1;
        bus.id_rs2         = s.id.rs2;
        bus.id_rd          = s.id.rd;
        bus.id_rs1_data    = s.id.d1;
        bus.id_rs2_data    = s.id.d2;
        bus.id_imm         = s.id.imm;
        bus.id_pc          = s.id.pc;
        bus.id_alu_control = s.id.ctl;
        bus.id_alu_src_a   = s.id.sa;
        bus.id_alu_src_b   = s.id.sb;
        bus.id_reg_write   = s.id.rw;
        bus.id_mem_read    = s.id.mr;
        bus.id_mem_write   = s.id.mw;
        bus.flush          = s.flush;
        bus.exm_rd         = s.exm_rd;
        bus.exm_reg_write  = s.exm_we;
        bus.exm_result     = s.exm_res;
        bus.wb_rd          = s.wb_rd;
        bus.wb_reg_write   = s.wb_we;
        bus.wb_result      = s.wb_res;
    endtask

    // One clock: the instruction chosen last cycle enters EX, new inputs are applied,
    // and the outputs they should produce are queued for the monitor.
    task automatic cycle(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        in_ex = next_in_ex;
        drive(s);
        e = predict(in_ex, s);
        exp_q.push_back(e);
        last_stall = e.stall;
        if (s.flush || hazard(in_ex, s) || !s.id.valid)
            next_in_ex = '0;
        else
            next_in_ex = s.id;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall_if_id",  32'(bus.stall_if_id),  32'(e.stall));
            chk("ex_valid",     32'(bus.ex_valid),     32'(e.valid));
            chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
            chk("ex_mem_read",  32'(bus.ex_mem_read),  32'(e.mr));
            chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(e.mw));
            chk("alu_control",  32'(bus.alu_control),  32'(e.ctl));
            chk("ex_rd",        32'(bus.ex_rd),        32'(e.rd));
            if (e.valid) begin
                chk("alu_a",         bus.alu_a,         e.a);
                chk("alu_b",         bus.alu_b,         e.b);
                chk("ex_store_data", bus.ex_store_data, e.sd);
                chk("ex_pc",         bus.ex_pc,         e.pc);
            end
        end
    end

    function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic mr, input logic mw);
        instr_t i;
        i = '0;
        i.valid = 1'b1;
        i.rs1 = rs1;
        i.rs2 = rs2;
        i.rd = rd;
        i.rw = (rd != 0);
        i.mr = mr;
        i.mw = mw;
        i.d1 = 32'h0000_dead;
        i.d2 = 32'h0000_beef;
        i.pc = 32'h0000_1000;
        i.ctl = 4'd0;
        return i;
    endfunction

    initial begin
        stim_t s;
        stim_t prev;
        in_ex = '0;
        next_in_ex = '0;
        last_stall = 1'b0;
        rst = 1'b1;
        drive(idle());
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_alu_control", 32'(bus.alu_control), 32'd0);
        chk("rst_stall", 32'(bus.stall_if_id), 32'd0);
        chk("rst_ex_pc", bus.ex_pc, 32'd0);
        rst = 1'b0;

        // Immediate operand; store data still follows rs2.
        s = idle();
        s.id = mk(5'd3, 5'd4, 5'd9, 1'b0, 1'b0);
        s.id.d1 = 32'h10;
        s.id.d2 = 32'h55;
        s.id.sb = 1'b1;
        s.id.imm = 32'hFFFF_FFFC;
        cycle(s);
        cycle(idle());
        @(negedge clk); #1;
        chk("imm_alu_a", bus.alu_a, 32'h10);
        chk("imm_alu_b", bus.alu_b, 32'hFFFF_FFFC);
        chk("imm_store", bus.ex_store_data, 32'h55);

        // Forward priority on rs1.
        s = idle();
        s.id = mk(5'd5, 5'd6, 5'd1, 1'b0, 1'b0);
        s.id.d1 = 32'h99;
        cycle(s);
        s = idle();
        s.exm_rd = 5'd5; s.exm_we = 1'b1; s.exm_res = 32'h11;
        s.wb_rd = 5'd5;  s.wb_we = 1'b1;  s.wb_res = 32'h22;
        cycle(s);
        @(negedge clk); #1;
        chk("fwd_exm_first", bus.alu_a, 32'h11);
        bus.exm_reg_write = 1'b0;
        #1;
        chk("fwd_wb_second", bus.alu_a, 32'h22);

        // x0 is never forwarded.
        s = idle();
        s.id = mk(5'd2, 5'd0, 5'd3, 1'b0, 1'b0);
        s.id.d2 = 32'h0;
        cycle(s);
        s = idle();
        s.exm_rd = 5'd0; s.exm_we = 1'b1; s.exm_res = 32'hFFFF;
        cycle(s);
        @(negedge clk); #1;
        chk("x0_alu_b", bus.alu_b, 32'h0);

        // Load-use: one stall, one bubble, then the consumer picks the load value off WB.
        s = idle();
        s.id = mk(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        cycle(s);
        s = idle();
        s.id = mk(5'd7, 5'd3, 5'd8, 1'b0, 1'b0);
        cycle(s);
        @(negedge clk); #1;
        chk("lu_stall", 32'(bus.stall_if_id), 32'd1);
        cycle(s);
        @(negedge clk); #1;
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_stall_once", 32'(bus.stall_if_id), 32'd0);
        s = idle();
        s.wb_rd = 5'd7; s.wb_we = 1'b1; s.wb_res = 32'h1234_5678;
        cycle(s);
        @(negedge clk); #1;
        chk("lu_wb_forward", bus.alu_a, 32'h1234_5678);

        // Flush beats load-use.
        s = idle();
        s.id = mk(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        cycle(s);
        s = idle();
        s.id = mk(5'd7, 5'd7, 5'd0, 1'b0, 1'b1);
        s.flush = 1'b1;
        cycle(s);
        @(negedge clk); #1;
        chk("flush_stall", 32'(bus.stall_if_id), 32'd0);
        cycle(idle());
        @(negedge clk); #1;
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_mem_write", 32'(bus.ex_mem_write), 32'd0);

        // Reset arriving in the middle of a stall.
        s = idle();
        s.id = mk(5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
        cycle(s);
        s = idle();
        s.id = mk(5'd4, 5'd1, 5'd5, 1'b0, 1'b0);
        s.id.sa = 1'b1;
        s.id.pc = 32'h0000_2000;
        cycle(s);
        @(negedge clk); #1;
        chk("pre_rst_stall", 32'(bus.stall_if_id), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("midrst_alu_a", bus.alu_a, 32'd0);
        chk("midrst_alu_b", bus.alu_b, 32'd0);
        chk("midrst_alu_control", 32'(bus.alu_control), 32'd0);
        chk("midrst_stall", 32'(bus.stall_if_id), 32'd0);
        drive(idle());
        @(negedge clk);
        rst = 1'b0;
        in_ex = '0;
        next_in_ex = '0;
        last_stall = 1'b0;

        // Random traffic; decode is held while the stage asks for a stall.
        prev = idle();
        for (int i = 0; i < 3000; i++) begin
            s = rand_stim();
            if (last_stall) s.id = prev.id;
            cycle(s);
            prev = s;
        end

        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
